// File: rtl/apb_timer_if.sv
// APB slave-side bus bundle for apb_timer: request signals from the interconnect,
// registered read data and response flags back.
interface apb_timer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer.sv
// APB timer: prescaled 32-bit up-counter with compare match, auto-reload/one-shot and level irq.
// Optional APB_TIMER_SLVERR_EN: flag PSLVERR on accesses to the unmapped offsets 0x14-0x1C.
module apb_timer #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    apb_timer_if.slave  apb,
    output logic        irq
);
    typedef enum logic [2:0] {
        A_CTRL    = 3'd0,
        A_PRESC   = 3'd1,
        A_COMPARE = 3'd2,
        A_COUNT   = 3'd3,
        A_STATUS  = 3'd4
    } reg_addr_e;

    logic               r_en;
    logic               r_auto;
    logic               r_irq_en;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [31:0]        r_compare;
    logic [31:0]        r_count;
    logic               r_match;
    logic [31:0]        r_prdata;

    logic [2:0]  w_addr;
    logic        w_wr;
    logic        w_rd_setup;
    logic        w_wr_ctrl;
    logic        w_wr_presc;
    logic        w_wr_cmp;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_cnt_evt;
    logic        w_match;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_addr      = apb.PADDR[4:2];
    assign w_wr        = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_rd_setup  = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    assign w_wr_ctrl   = w_wr & (w_addr == A_CTRL);
    assign w_wr_presc  = w_wr & (w_addr == A_PRESC);
    assign w_wr_cmp    = w_wr & (w_addr == A_COMPARE);
    assign w_wr_count  = w_wr & (w_addr == A_COUNT);
    assign w_wr_status = w_wr & (w_addr == A_STATUS);

    // A COUNT write in a tick cycle suppresses both the increment and the match test.
    assign w_tick    = r_en & (r_presc_cnt == r_presc);
    assign w_cnt_evt = w_tick & ~w_wr_count;
    assign w_match   = w_cnt_evt & (r_count == r_compare);

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_CTRL:    w_rdata = {29'd0, r_irq_en, r_auto, r_en};
            A_PRESC:   w_rdata = 32'(r_presc);
            A_COMPARE: w_rdata = r_compare;
            A_COUNT:   w_rdata = r_count;
            A_STATUS:  w_rdata = {31'd0, r_match};
            default:   w_rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_en        <= 1'b0;
            r_auto      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_compare   <= '0;
            r_count     <= '0;
            r_match     <= 1'b0;
            r_prdata    <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= apb.PWDATA[0];
                r_auto   <= apb.PWDATA[1];
                r_irq_en <= apb.PWDATA[2];
            end else if (w_match && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr_ctrl && !apb.PWDATA[0]) begin
                r_presc_cnt <= '0;
            end else if (r_en) begin
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
            end

            if (w_wr_presc) r_presc   <= apb.PWDATA[PRESC_W-1:0];
            if (w_wr_cmp)   r_compare <= apb.PWDATA;

            if (w_wr_count) begin
                r_count <= apb.PWDATA;
            end else if (w_match) begin
                if (r_auto) r_count <= '0;
            end else if (w_cnt_evt) begin
                r_count <= r_count + 32'd1;
            end

            // A new match outranks a simultaneous write-1-to-clear.
            if (w_match) begin
                r_match <= 1'b1;
            end else if (w_wr_status && apb.PWDATA[0]) begin
                r_match <= 1'b0;
            end

            if (w_rd_setup) r_prdata <= w_rdata;
        end
    end

    assign apb.PRDATA = r_prdata;
    assign apb.PREADY = 1'b1;
    assign irq        = r_match & r_irq_en;

`ifdef APB_TIMER_SLVERR_EN
    logic w_unmapped;
    assign w_unmapped  = (w_addr > A_STATUS);
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & w_unmapped;
`else
    assign apb.PSLVERR = 1'b0;
`endif

    assign w_unused = ^{apb.PADDR[31:5], apb.PADDR[1:0]};
endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: every APB transfer pushes its expected response,
// a negedge monitor pops and compares it in the access phase; irq timing checked inline.
module tb_apb_timer;
    localparam logic [31:0] CTRL    = 32'h00;
    localparam logic [31:0] PRESC   = 32'h04;
    localparam logic [31:0] COMPARE = 32'h08;
    localparam logic [31:0] COUNT   = 32'h0C;
    localparam logic [31:0] STATUS  = 32'h10;

    logic PCLK = 1'b0;
    logic PRESETn;
    logic irq;

    apb_timer_if bus();

    apb_timer #(.PRESC_W(16)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus.slave),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] a);
`ifdef APB_TIMER_SLVERR_EN
        return a[4:2] > 3'd4;
`else
        return 1'b0;
`endif
    endfunction

    // Caller sits just after a rising edge; returns 1ns after the access-phase edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input string name);
        exp_t e;
        e.name = name;
        e.wr   = wr;
        e.data = data;
        e.err  = exp_err(addr);
        sbq.push_back(e);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wr ? data : 32'd0;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        apb_xfer(1'b1, addr, data, "wr");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        apb_xfer(1'b0, addr, exp, name);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge PCLK); #1;
        end
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        cyc(2);
        PRESETn = 1'b1;
        cyc(1);
    endtask

    always @(negedge PCLK) begin : monitor
        exp_t e;
        if (PRESETn && bus.PSEL && bus.PENABLE) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_xfer: got access phase expected none at %0t", $time);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_pready"}, 32'(bus.PREADY), 32'd1);
                check({e.name, "_pslverr"}, 32'(bus.PSLVERR), 32'(e.err));
                if (!e.wr) check(e.name, bus.PRDATA, e.data);
            end
        end
    end

    task automatic wrap_probe(input int idle, input logic [31:0] exp, input string name);
        do_reset();
        wr(COMPARE, 32'h10);
        wr(COUNT, 32'hFFFF_FFFE);
        wr(CTRL, 32'h1);
        cyc(idle);
        rd(COUNT, exp, name);
        rd(STATUS, 32'h0, "wrap_no_match");
    endtask

    initial begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        PRESETn     = 1'b0;
        cyc(2);
        PRESETn = 1'b1;
        cyc(1);

        // reset values
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_prdata", bus.PRDATA, 32'd0);
        for (int i = 0; i < 8; i++) rd(32'(i * 4), 32'd0, "rst_rd");
        check("rst_irq_after_reads", 32'(irq), 32'd0);

        // auto-reload: PRESC=0, COMPARE=4 -> match every 5 cycles
        do_reset();
        wr(PRESC, 32'd0);
        wr(COMPARE, 32'd4);
        wr(CTRL, 32'h7);
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            check("ar_irq_early", 32'(irq), 32'd0);
        end
        cyc(1);
        check("ar_irq_match", 32'(irq), 32'd1);
        rd(COUNT, 32'd0, "ar_count_reload");
        wr(STATUS, 32'h1);
        check("ar_irq_w1c", 32'(irq), 32'd0);
        cyc(1);
        check("ar_irq_second", 32'(irq), 32'd1);
        rd(STATUS, 32'h1, "ar_status");

        // prescaled one-shot: match lands exactly 12 cycles after EN commit
        do_reset();
        wr(COMPARE, 32'd2);
        wr(PRESC, 32'd3);
        wr(CTRL, 32'h1);
        cyc(10);
        rd(STATUS, 32'h0, "os_status_c11");
        rd(STATUS, 32'h1, "os_status_c13");
        rd(CTRL, 32'h0, "os_ctrl_cleared");
        rd(COUNT, 32'd2, "os_count");
        cyc(8);
        rd(COUNT, 32'd2, "os_count_hold");
        check("os_irq_disabled", 32'(irq), 32'd0);

        // COUNT write on a tick cycle wins over the increment
        do_reset();
        wr(COMPARE, 32'hFFFF_0000);
        wr(PRESC, 32'd0);
        wr(CTRL, 32'h1);
        wr(COUNT, 32'h100);
        rd(COUNT, 32'h100, "col_count_written");
        rd(COUNT, 32'h102, "col_count_running");

        // wrap through 0xFFFFFFFF without a match
        wrap_probe(1, 32'hFFFF_FFFF, "wrap_ffffffff");
        wrap_probe(2, 32'h0, "wrap_zero");

        // W1C on the match edge: set wins
        do_reset();
        wr(COMPARE, 32'd3);
        wr(CTRL, 32'h7);
        cyc(6);
        wr(STATUS, 32'h1);
        check("sw_irq_held", 32'(irq), 32'd1);
        rd(STATUS, 32'h1, "sw_status");

        // CTRL write on the one-shot match edge wins over the auto-clear of EN
        do_reset();
        wr(COMPARE, 32'd2);
        wr(CTRL, 32'h1);
        cyc(1);
        wr(CTRL, 32'h5);
        check("cw_irq", 32'(irq), 32'd1);
        rd(CTRL, 32'h5, "cw_ctrl");

        // asynchronous reset mid-operation; counter stays stopped afterwards
        do_reset();
        wr(CTRL, 32'h7);
        cyc(2);
        check("ar2_irq_running", 32'(irq), 32'd1);
        #2 PRESETn = 1'b0;
        #1 check("async_rst_irq", 32'(irq), 32'd0);
        cyc(2);
        PRESETn = 1'b1;
        cyc(5);
        rd(COUNT, 32'd0, "post_rst_count");
        rd(CTRL, 32'd0, "post_rst_ctrl");
        rd(STATUS, 32'd0, "post_rst_status");

        // unmapped offset 0x18
        do_reset();
        wr(COMPARE, 32'h1234);
        wr(CTRL, 32'h6);
        wr(32'h18, 32'hFFFF_FFFF);
        rd(32'h18, 32'd0, "unmap_rd");
        rd(CTRL, 32'h6, "unmap_ctrl_kept");
        rd(COMPARE, 32'h1234, "unmap_cmp_kept");

        cyc(2);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
